cpu_control_unit: RTL and testbench

//  Multi-cycle FSM sequencing the 16-bit RISC execution unit (IR, PC, integer datapath, address mux).

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/cpu_control_unit_decode.sv | 47 ++++
 rtl/cpu_control_unit.sv | 146 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, ALU selects, state encodings and branch-condition helper
// for the 16-bit RISC control unit.
package cpu_pkg;

  localparam logic [6:0] OP_LD  = 7'h70;
  localparam logic [6:0] OP_ST  = 7'h71;
  localparam logic [6:0] OP_JMP = 7'h78;
  localparam logic [6:0] OP_JC  = 7'h79;
  localparam logic [6:0] OP_JNC = 7'h7A;
  localparam logic [6:0] OP_JZ  = 7'h7B;
  localparam logic [6:0] OP_JNZ = 7'h7C;
  localparam logic [6:0] OP_JN  = 7'h7D;
  localparam logic [6:0] OP_JR  = 7'h7E;
  localparam logic [6:0] OP_HLT = 7'h7F;

  localparam logic [3:0] ALU_PASS_S = 4'h0;
  localparam logic [3:0] ALU_PASS_R = 4'h1;

  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_ALU     = 4'd3,
    ST_LOAD    = 4'd4,
    ST_STORE   = 4'd5,
    ST_BRANCH  = 4'd6,
    ST_JR      = 4'd7,
    ST_HALT    = 4'd8,
    ST_ILLEGAL = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    BC_ALWAYS = 3'd0,
    BC_C      = 3'd1,
    BC_NC     = 3'd2,
    BC_Z      = 3'd3,
    BC_NZ     = 3'd4,
    BC_N      = 3'd5
  } br_cond_e;

  function automatic logic br_taken(
    input br_cond_e cond,
    input logic     c,
    input logic     n,
    input logic     z
  );
    logic t;
    case (cond)
      BC_ALWAYS: t = 1'b1;
      BC_C:      t = c;
      BC_NC:     t = ~c;
      BC_Z:      t = z;
      BC_NZ:     t = ~z;
      BC_N:      t = n;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cpu_control_unit_decode.sv
// Opcode decoder: maps IR opcode to the execute state, the branch
// condition and a legality flag. Purely combinational.
module cpu_cu_decode
  import cpu_pkg::*;
(
  input  logic [6:0] op,
  output state_e     exec_state,
  output br_cond_e   br_cond,
  output logic       legal
);

  always_comb begin
    exec_state = ST_ILLEGAL;
    br_cond    = BC_ALWAYS;
    legal      = 1'b1;
    unique case (1'b1)
      (op[6:4] == 3'b000): exec_state = ST_ALU;
      (op == OP_LD):       exec_state = ST_LOAD;
      (op == OP_ST):       exec_state = ST_STORE;
      (op == OP_JMP):      exec_state = ST_BRANCH;
      (op == OP_JC): begin
        exec_state = ST_BRANCH;
        br_cond    = BC_C;
      end
      (op == OP_JNC): begin
        exec_state = ST_BRANCH;
        br_cond    = BC_NC;
      end
      (op == OP_JZ): begin
        exec_state = ST_BRANCH;
        br_cond    = BC_Z;
      end
      (op == OP_JNZ): begin
        exec_state = ST_BRANCH;
        br_cond    = BC_NZ;
      end
      (op == OP_JN): begin
        exec_state = ST_BRANCH;
        br_cond    = BC_N;
      end
      (op == OP_JR):       exec_state = ST_JR;
      (op == OP_HLT):      exec_state = ST_HALT;
      default:             legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit RISC execution unit:
// fetch/decode/execute sequencing, single-step support, retire counter.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [15:0]      ir_out,
  input  logic             C,
  input  logic             N,
  input  logic             Z,
  output logic             ir_ld,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             pc_sel,
  output logic             adr_sel,
  output logic             S_Sel,
  output logic             W_En,
  output logic [2:0]       W_Adr,
  output logic [2:0]       R_Adr,
  output logic [2:0]       S_Adr,
  output logic [3:0]       Alu_Op,
  output logic             mw_en,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic             step_q, step_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e   dec_state;
  br_cond_e dec_cond;
  logic     dec_legal;
  logic     step_rise;
  logic     go;

  cpu_cu_decode u_decode (
    .op         (ir_out[15:9]),
    .exec_state (dec_state),
    .br_cond    (dec_cond),
    .legal      (dec_legal)
  );

  // A step edge seen outside FETCH is held until FETCH consumes it.
  assign step_rise = step & ~step_q;
  assign go        = run | step_rise | pend_q;

  always_comb begin
    state_d = state_q;
    step_d  = step;
    pend_d  = pend_q | step_rise;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (go) begin
          state_d = ST_DECODE;
          pend_d  = 1'b0;
        end
      end
      ST_DECODE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!dec_legal && !HALT_ON_ILLEGAL)
          state_d = ST_FETCH;
        else
          state_d = dec_state;
      end
      ST_ALU, ST_LOAD, ST_STORE, ST_BRANCH, ST_JR:
        state_d = ST_FETCH;
      ST_HALT, ST_ILLEGAL: state_d = state_q;
      default: state_d = ST_RESET;
    endcase
    if (reset) begin
      state_d = ST_RESET;
      step_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    step_q  <= step_d;
    pend_q  <= pend_d;
    cnt_q   <= cnt_d;
  end

  // Strobes are forced low while reset is high so no write lands on it.
  always_comb begin
    ir_ld   = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_sel  = 1'b0;
    adr_sel = 1'b0;
    S_Sel   = 1'b0;
    W_En    = 1'b0;
    mw_en   = 1'b0;
    Alu_Op  = ALU_PASS_S;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          ir_ld  = go;
          pc_inc = go;
        end
        ST_ALU: begin
          W_En   = 1'b1;
          Alu_Op = ir_out[12:9];
        end
        ST_LOAD: begin
          adr_sel = 1'b1;
          S_Sel   = 1'b1;
          W_En    = 1'b1;
        end
        ST_STORE: begin
          adr_sel = 1'b1;
          mw_en   = 1'b1;
        end
        ST_BRANCH: pc_ld = br_taken(dec_cond, C, N, Z);
        ST_JR: begin
          Alu_Op = ALU_PASS_R;
          pc_sel = 1'b1;
          pc_ld  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign W_Adr     = ir_out[8:6];
  assign R_Adr     = ir_out[5:3];
  assign S_Adr     = ir_out[2:0];
  assign halted    = (state_q == ST_HALT) || (state_q == ST_ILLEGAL);
  assign illegal   = (state_q == ST_ILLEGAL);
  assign state_dbg = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: sequencing, strobes, stepping,
// halt/illegal, reset mid-instruction and counter wrap.
module tb_cpu_control_unit;

  localparam logic [15:0] I_ADD = 16'h0453;
  localparam logic [15:0] I_LD  = 16'hE0D0;
  localparam logic [15:0] I_ST  = 16'hE215;
  localparam logic [15:0] I_JZ  = 16'hF6FE;
  localparam logic [15:0] I_JR  = 16'hFC20;
  localparam logic [15:0] I_HLT = 16'hFE00;
  localparam logic [15:0] I_BAD = 16'h8000;

  logic clk = 1'b0;
  logic reset, run, step, c_f, n_f, z_f;
  logic [15:0] ir;
  logic ir_ld, pc_ld, pc_inc, pc_sel, adr_sel, s_sel, w_en, mw_en;
  logic halted, illegal;
  logic [2:0] w_adr, r_adr, s_adr;
  logic [3:0] alu_op, state_dbg, instr_cnt;
  logic n_ir_ld, n_pc_ld, n_pc_inc, n_pc_sel, n_adr_sel, n_s_sel;
  logic n_w_en, n_mw_en, n_halted, n_illegal;
  logic [2:0] n_w_adr, n_r_adr, n_s_adr;
  logic [3:0] n_alu_op, n_state;
  logic [15:0] n_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_control_unit #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .ir_out(ir),
    .C(c_f), .N(n_f), .Z(z_f),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .adr_sel(adr_sel), .S_Sel(s_sel), .W_En(w_en),
    .W_Adr(w_adr), .R_Adr(r_adr), .S_Adr(s_adr), .Alu_Op(alu_op),
    .mw_en(mw_en), .halted(halted), .illegal(illegal),
    .state_dbg(state_dbg), .instr_cnt(instr_cnt)
  );

  cpu_control_unit #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .run(run), .step(step), .ir_out(ir),
    .C(c_f), .N(n_f), .Z(z_f),
    .ir_ld(n_ir_ld), .pc_ld(n_pc_ld), .pc_inc(n_pc_inc),
    .pc_sel(n_pc_sel), .adr_sel(n_adr_sel), .S_Sel(n_s_sel),
    .W_En(n_w_en), .W_Adr(n_w_adr), .R_Adr(n_r_adr),
    .S_Adr(n_s_adr), .Alu_Op(n_alu_op), .mw_en(n_mw_en),
    .halted(n_halted), .illegal(n_illegal),
    .state_dbg(n_state), .instr_cnt(n_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    c_f = 1'b0; n_f = 1'b0; z_f = 1'b0; ir = I_ADD;
    tick(); tick();
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_strobes", 32'({ir_ld, pc_ld, pc_inc, w_en, mw_en, halted}), 32'd0);
    chk("rst_wadr", 32'(w_adr), 32'd1);

    reset = 1'b0; run = 1'b1;
    tick();
    chk("add_fetch_st", 32'(state_dbg), 32'd1);
    chk("add_fetch_sb", 32'({ir_ld, pc_inc, adr_sel, w_en}), 32'b1100);
    tick();
    chk("add_dec_st", 32'(state_dbg), 32'd2);
    chk("add_dec_sb", 32'({ir_ld, pc_inc, w_en, pc_ld}), 32'd0);
    tick();
    chk("add_alu_st", 32'(state_dbg), 32'd3);
    chk("add_alu_sb", 32'({w_en, s_sel, mw_en}), 32'b100);
    chk("add_aluop", 32'(alu_op), 32'd2);
    chk("add_adr", 32'({w_adr, r_adr, s_adr}), 32'b001_010_011);
    chk("add_cnt", 32'(instr_cnt), 32'd1);

    ir = I_LD;
    tick(); tick(); tick();
    chk("ld_st", 32'(state_dbg), 32'd4);
    chk("ld_sb", 32'({adr_sel, s_sel, w_en, mw_en}), 32'b1110);
    chk("ld_aluop", 32'(alu_op), 32'd0);
    chk("ld_adr", 32'({w_adr, r_adr}), 32'b011_010);

    ir = I_ST;
    tick(); tick(); tick();
    chk("st_st", 32'(state_dbg), 32'd5);
    chk("st_sb", 32'({adr_sel, mw_en, w_en}), 32'b110);
    chk("st_cnt", 32'(instr_cnt), 32'd3);

    ir = I_JZ; z_f = 1'b1;
    tick(); tick(); tick();
    chk("jz_t_st", 32'(state_dbg), 32'd6);
    chk("jz_t_sb", 32'({pc_ld, pc_sel, pc_inc}), 32'b100);
    z_f = 1'b0;
    #1;
    chk("jz_flag_now", 32'(pc_ld), 32'd0);
    tick(); tick(); tick();
    chk("jz_nt_st", 32'(state_dbg), 32'd6);
    chk("jz_nt_pcld", 32'(pc_ld), 32'd0);

    ir = I_JR;
    tick(); tick(); tick();
    chk("jr_st", 32'(state_dbg), 32'd7);
    chk("jr_sb", 32'({pc_sel, pc_ld, pc_inc}), 32'b110);
    chk("jr_aluop", 32'(alu_op), 32'd1);
    chk("jr_cnt", 32'(instr_cnt), 32'd6);

    run = 1'b0; ir = I_ADD;
    tick();
    chk("stp_wait_st", 32'(state_dbg), 32'd1);
    chk("stp_wait_ld", 32'(ir_ld), 32'd0);
    step = 1'b1;
    #1;
    chk("stp_edge_ld", 32'(ir_ld), 32'd1);
    repeat (10) tick();
    chk("stp_held_cnt", 32'(instr_cnt), 32'd7);
    chk("stp_held_st", 32'(state_dbg), 32'd1);
    chk("stp_held_ld", 32'(ir_ld), 32'd0);
    step = 1'b0;
    tick();
    step = 1'b1;
    #1;
    chk("stp2_edge_ld", 32'(ir_ld), 32'd1);
    tick(); tick(); tick();
    chk("stp2_cnt", 32'(instr_cnt), 32'd8);

    ir = I_HLT; run = 1'b1; step = 1'b0;
    tick(); tick();
    chk("hlt_st", 32'(state_dbg), 32'd8);
    chk("hlt_flags", 32'({halted, illegal}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      run = ~run; step = ~step;
      tick();
    end
    chk("hlt_hold_st", 32'(state_dbg), 32'd8);
    chk("hlt_hold_cnt", 32'(instr_cnt), 32'd9);
    chk("hlt_hold_ld", 32'(ir_ld), 32'd0);

    reset = 1'b1; run = 1'b1; step = 1'b0;
    tick();
    chk("hrst_st", 32'(state_dbg), 32'd0);
    chk("hrst_flags", 32'({halted, illegal, instr_cnt}), 32'd0);
    reset = 1'b0; ir = I_BAD;
    tick(); tick(); tick();
    chk("ill_st", 32'(state_dbg), 32'd9);
    chk("ill_flags", 32'({halted, illegal}), 32'b11);
    chk("ill_cnt", 32'(instr_cnt), 32'd1);
    chk("nop_st", 32'(n_state), 32'd1);
    chk("nop_flags", 32'({n_halted, n_illegal, n_w_en}), 32'd0);
    chk("nop_cnt", 32'(n_cnt), 32'd1);

    reset = 1'b1;
    tick();
    reset = 1'b0; ir = I_LD;
    tick(); tick(); tick();
    chk("ldr_pre_wen", 32'(w_en), 32'd1);
    chk("ldr_pre_cnt", 32'(instr_cnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("ldr_gate_wen", 32'(w_en), 32'd0);
    tick();
    chk("ldr_st", 32'(state_dbg), 32'd0);
    chk("ldr_sb", 32'({w_en, mw_en, instr_cnt}), 32'd0);
    reset = 1'b0; ir = I_ST;
    tick(); tick(); tick();
    chk("str_pre_mw", 32'(mw_en), 32'd1);
    reset = 1'b1;
    tick();
    chk("str_st", 32'(state_dbg), 32'd0);
    chk("str_sb", 32'({w_en, mw_en, instr_cnt}), 32'd0);

    reset = 1'b0; ir = I_ADD;
    repeat (45) tick();
    chk("wrap_max", 32'(instr_cnt), 32'd15);
    repeat (3) tick();
    chk("wrap_zero", 32'(instr_cnt), 32'd0);
    chk("wrap_st", 32'(state_dbg), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
